// File: rtl/qlearn_pkg.sv
// Shared constants and types for the Q-learning action-selection blocks.
// Contents:
//   scan_state_e - scan/hold state of qmax_scan
//   LfsrSeed     - reset value of the exploration LFSR
//   LfsrPoly     - Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1
package qlearn_pkg;

  typedef enum logic {
    StScan = 1'b0,
    StHold = 1'b1
  } scan_state_e;

  localparam logic [15:0] LfsrSeed = 16'hACE1;
  // Right-shifting Galois form: taps 16, 14, 13, 11 map to bits 15, 13, 12, 10.
  localparam logic [15:0] LfsrPoly = 16'hB400;

endpackage

// File: rtl/qlearn_lfsr.sv
// 16-bit Galois LFSR, advancing once per clock, used as the exploration
// random source of qmax_scan.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset, loads LfsrSeed
//   lfsr  - current LFSR state
module qlearn_lfsr
  import qlearn_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LfsrPoly;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/qmax_scan.sv
// Streaming arg-max over NUM_ACTIONS signed Q-values. Samples arrive in action
// order; after the last one the block holds {out_value, out_arg} until the
// consumer takes it, then scans again. Ties keep the lower action index.
// Optional epsilon-greedy selection is compiled in with QMAX_EPS_GREEDY_EN:
// at sample 0 a random action k and a random draw r are taken from an LFSR,
// and if r < eps_threshold the result is sample k instead of the maximum.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   clear               - synchronous abort of the scan or pending result
//   in_valid/in_ready   - Q-value input handshake, in_data the sample
//   out_valid/out_ready - result handshake
//   out_value, out_arg  - selected Q-value and its action index
//   eps_threshold       - exploration threshold (QMAX_EPS_GREEDY_EN only)
//   out_explore         - result came from exploration (QMAX_EPS_GREEDY_EN only)
module qmax_scan
  import qlearn_pkg::*;
#(
  parameter int unsigned DATA_LENGTH = 32,
  parameter int unsigned NUM_ACTIONS = 4,
  parameter int unsigned EPS_LENGTH  = 8,
  localparam int unsigned ARG_LENGTH = $clog2(NUM_ACTIONS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DATA_LENGTH-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [DATA_LENGTH-1:0] out_value,
  output logic        [ARG_LENGTH-1:0]  out_arg
`ifdef QMAX_EPS_GREEDY_EN
  ,
  input  logic        [EPS_LENGTH-1:0]  eps_threshold,
  output logic                          out_explore
`endif
);

  if (NUM_ACTIONS < 2 || NUM_ACTIONS > 256) begin : g_bad_num_actions
    $error("qmax_scan: NUM_ACTIONS must be in 2..256");
  end
  if (EPS_LENGTH < 1 || EPS_LENGTH > 16) begin : g_bad_eps_length
    $error("qmax_scan: EPS_LENGTH must be in 1..16");
  end

  localparam logic [ARG_LENGTH-1:0] LastIdx = ARG_LENGTH'(NUM_ACTIONS - 1);

  scan_state_e                   state_q, state_d;
  logic        [ARG_LENGTH-1:0]  cnt_q, cnt_d;
  logic signed [DATA_LENGTH-1:0] max_q, max_d;
  logic        [ARG_LENGTH-1:0]  max_arg_q, max_arg_d;
  logic signed [DATA_LENGTH-1:0] value_q, value_d;
  logic        [ARG_LENGTH-1:0]  arg_q, arg_d;

  logic                          first, last;
  logic signed [DATA_LENGTH-1:0] greedy_value, sel_value;
  logic        [ARG_LENGTH-1:0]  greedy_arg, sel_arg;

  assign first = (cnt_q == '0);
  assign last  = (cnt_q == LastIdx);

  // Running maximum including the sample on in_data; sample 0 always loads.
  always_comb begin
    if (first || (in_data > max_q)) begin
      greedy_value = in_data;
      greedy_arg   = cnt_q;
    end else begin
      greedy_value = max_q;
      greedy_arg   = max_arg_q;
    end
  end

`ifdef QMAX_EPS_GREEDY_EN
  logic [15:0]                   lfsr;
  logic [ARG_LENGTH-1:0]         k_raw, k_draw, k_q, k_d, cur_k;
  logic                          explore_draw, explore_q, explore_d, cur_explore;
  logic signed [DATA_LENGTH-1:0] pick_q, pick_d;
  logic                          out_explore_q, out_explore_d, sel_explore;

  qlearn_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .lfsr  (lfsr)
  );

  assign k_raw        = lfsr[ARG_LENGTH-1:0];
  // Fold out-of-range draws back into 0..NUM_ACTIONS-1.
  assign k_draw       = (32'(k_raw) >= NUM_ACTIONS) ? ARG_LENGTH'(32'(k_raw) - NUM_ACTIONS)
                                                     : k_raw;
  assign explore_draw = (lfsr[15 -: EPS_LENGTH] < eps_threshold);

  // The draw is taken while sample 0 is on the input, so use it directly then.
  assign cur_k       = first ? k_draw : k_q;
  assign cur_explore = first ? explore_draw : explore_q;

  always_comb begin
    k_d       = k_q;
    explore_d = explore_q;
    pick_d    = pick_q;
    if (state_q == StScan && in_valid && !clear) begin
      k_d       = cur_k;
      explore_d = cur_explore;
      if (cnt_q == cur_k) begin
        pick_d = in_data;
      end
    end
  end

  always_comb begin
    if (cur_explore) begin
      sel_value   = (cnt_q == cur_k) ? in_data : pick_q;
      sel_arg     = cur_k;
      sel_explore = 1'b1;
    end else begin
      sel_value   = greedy_value;
      sel_arg     = greedy_arg;
      sel_explore = 1'b0;
    end
  end

  always_comb begin
    out_explore_d = out_explore_q;
    if (state_q == StScan && in_valid && !clear && last) begin
      out_explore_d = sel_explore;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q           <= '0;
      explore_q     <= 1'b0;
      pick_q        <= '0;
      out_explore_q <= 1'b0;
    end else begin
      k_q           <= k_d;
      explore_q     <= explore_d;
      pick_q        <= pick_d;
      out_explore_q <= out_explore_d;
    end
  end

  assign out_explore = out_explore_q;
`else
  assign sel_value = greedy_value;
  assign sel_arg   = greedy_arg;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    max_d     = max_q;
    max_arg_d = max_arg_q;
    value_d   = value_q;
    arg_d     = arg_q;
    unique case (state_q)
      StScan: begin
        if (clear) begin
          cnt_d = '0;
        end else if (in_valid) begin
          max_d     = greedy_value;
          max_arg_d = greedy_arg;
          if (last) begin
            cnt_d   = '0;
            value_d = sel_value;
            arg_d   = sel_arg;
            state_d = StHold;
          end else begin
            cnt_d = cnt_q + ARG_LENGTH'(1);
          end
        end
      end
      StHold: begin
        if (clear || out_ready) begin
          state_d = StScan;
        end
      end
      default: state_d = StScan;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StScan;
      cnt_q     <= '0;
      max_q     <= '0;
      max_arg_q <= '0;
      value_q   <= '0;
      arg_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      max_q     <= max_d;
      max_arg_q <= max_arg_d;
      value_q   <= value_d;
      arg_q     <= arg_d;
    end
  end

  assign in_ready  = (state_q == StScan);
  assign out_valid = (state_q == StHold);
  assign out_value = value_q;
  assign out_arg   = arg_q;

endmodule

// File: doc/qmax_scan.md
QMAX_SCAN -- requirements
Module: qmax_scan

Interface
REQ-001 SHALL have parameter DATA_LENGTH, default 32, meaning signed Q-value width.
REQ-002 SHALL have parameter NUM_ACTIONS, default 4, meaning Q-values per scan (legal range 2..256).
REQ-003 SHALL have parameter EPS_LENGTH, default 8, meaning epsilon threshold width (legal range 1..16).
REQ-004 SHALL derive localparam ARG_LENGTH = $clog2(NUM_ACTIONS).
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port clear, input, 1 bit, synchronous abort of the scan in progress.
REQ-008 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, DATA_LENGTH, signed), a Q-value stream in action order 0..NUM_ACTIONS-1.
REQ-009 SHALL have ports out_valid (input-side output, 1) and out_ready (input, 1), the result handshake.
REQ-010 SHALL have ports out_value (output, DATA_LENGTH, signed) and out_arg (output, ARG_LENGTH), the selected Q-value and its action index.
REQ-011 SHALL have ports eps_threshold (input, EPS_LENGTH) and out_explore (output, 1), present only when QMAX_EPS_GREEDY_EN is defined.

Function
REQ-012 SHALL implement two states: SCAN (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-013 SHALL accept a sample in SCAN on each cycle with in_valid=1, incrementing an index counter from 0.
REQ-014 SHALL load the first sample (index 0) unconditionally as the running maximum, with arg 0.
REQ-015 SHALL replace the running maximum only when the sample is strictly greater under signed comparison; ties keep the lower index.
REQ-016 SHALL move to HOLD on the cycle after sample NUM_ACTIONS-1 is accepted, so out_valid rises exactly one cycle after the last accept.
REQ-017 SHALL hold out_value, out_arg and out_explore stable while out_valid=1 and out_ready=0.
REQ-018 SHALL return to SCAN with the counter at 0 on the cycle after out_valid and out_ready are both 1; in_ready rises in that same next cycle (no input/output overlap).
REQ-019 SHALL, when clear=1 in SCAN, discard the partial scan, reset the counter to 0 and ignore in_valid in that cycle.
REQ-020 SHALL, when clear=1 in HOLD, drop the result and return to SCAN; clear has priority over out_ready.
REQ-021 SHALL ignore in_valid and in_data while in HOLD.
REQ-022 SHALL treat gaps in in_valid as stalls with no effect on state.

Reset
REQ-023 SHALL, on rst_n low, enter SCAN asynchronously with counter=0, out_valid=0, in_ready=1 (after release), out_value=0, out_arg=0, out_explore=0.
REQ-024 SHALL abandon any partial scan or pending result on reset mid-operation; no result is produced for it.

Configuration
REQ-025 SHALL, with QMAX_EPS_GREEDY_EN defined, include a 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1, reset seed 16'hACE1) advancing every cycle.
REQ-026 SHALL, with the macro defined, on accepting sample 0 draw r = lfsr[15 -: EPS_LENGTH] and k = lfsr[ARG_LENGTH-1:0], folded to k-NUM_ACTIONS when k >= NUM_ACTIONS.
REQ-027 SHALL, with the macro defined and r < eps_threshold, output the sample at index k and arg k, with out_explore=1; otherwise the greedy result, with out_explore=0.
REQ-028 SHALL, without the macro, contain no LFSR, no eps_threshold or out_explore ports, and always output the greedy result.

Structure
REQ-029 SHALL place the state enum, LFSR seed and polynomial constants in shared package qlearn_pkg.
REQ-030 SHALL instantiate the LFSR as sub-module qlearn_lfsr, only under QMAX_EPS_GREEDY_EN.

Verification
REQ-031 SHALL check NUM_ACTIONS=4 with stream 5,-3,9,2 -> out_value=9, out_arg=2, out_valid one cycle after the 4th accept.
REQ-032 SHALL check tie 7,7,-1,7 -> out_arg=0; and all-negative -8,-2,-5,-2 -> out_value=-2, out_arg=1.
REQ-033 SHALL check out_ready held low 10 cycles -> outputs stable, in_ready=0, extra in_valid ignored; next scan 1,2,3,4 -> arg 3.
REQ-034 SHALL check clear after 2 of 4 samples, then 0,0,0,1 -> out_arg=3; and rst_n pulse in HOLD -> out_valid=0 immediately.
REQ-035 SHALL check NUM_ACTIONS=5, DATA_LENGTH=16 with 32767 at index 4 -> out_arg=4.
REQ-036 SHALL check, with the macro, eps_threshold=0 -> out_explore never 1; eps_threshold=2^EPS_LENGTH-1 over 1000 scans -> out_explore rate above 99% and every arg within 0..NUM_ACTIONS-1.
